q_table_ctrl: RTL
=================

Q_TABLE_CTRL -- requirements
Module: q_table_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6: state-index width; table depth is 2^ADDR_W rows.
REQ-002 SHALL have port clock, input, 1: single clock; all logic is rising-edge.
REQ-003 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1: update request present.
REQ-005 SHALL have port req_ready, output, 1: controller can accept a request.
REQ-006 SHALL have port state_idx, input, ADDR_W: row of the current state.
REQ-007 SHALL have port next_idx, input, ADDR_W: row of the next state.
REQ-008 SHALL have port action_in, input, 4: taken action; 1..9 legal.
REQ-009 SHALL have port reward_in, input, 16: reward for the transition.
REQ-010 SHALL have ports data_out1..data_out9, output, 16 each: Q-row lanes 1..9 driven to the Q-learning accelerator's data inputs.
REQ-011 SHALL have port action_out, output, 4: latched action driven to the accelerator.
REQ-012 SHALL have port reward_out, output, 16: latched reward driven to the accelerator.
REQ-013 SHALL have port q_new, input, 16: updated Q-value returned by the accelerator.
REQ-014 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port q_written, output, 16: value committed, valid with done.
REQ-016 SHALL have port err, output, 1: illegal-action flag, valid with done.

Function
REQ-017 SHALL run FSM IDLE -> RD_S -> PRES_S -> PRES_NS -> DONE -> IDLE, one cycle per non-IDLE state.
REQ-018 SHALL assert req_ready only in IDLE; accept on req_valid&&req_ready; latch state_idx, next_idx, action_in and reward_in.
REQ-019 SHALL issue a RAM read of row state_idx in RD_S, with one-cycle read latency.
REQ-020 SHALL drive row(state_idx) on data_out1..9 in PRES_S and issue the read of row next_idx.
REQ-021 SHALL drive row(next_idx) on data_out1..9 in PRES_NS and sample q_new at the end of PRES_NS.
REQ-022 SHALL write q_new to row state_idx, lane action, at the PRES_NS->DONE edge when action is 1..9; other lanes are unchanged.
REQ-023 SHALL NOT write for action 0 or 10..15; err=1 in DONE.
REQ-024 SHALL pulse done for one cycle in DONE, with q_written equal to the sampled q_new; accept-to-done latency is exactly 4 cycles.
REQ-025 SHALL drive action_out and reward_out with the latched values in PRES_S and PRES_NS, and 0 otherwise.
REQ-026 SHALL drive data_out lanes to 0 outside PRES_S and PRES_NS.
REQ-027 SHALL handle state_idx==next_idx by presenting the same row twice, pre-update.
REQ-028 SHALL give back-to-back accepts a minimum spacing of 5 cycles; the next read observes the prior write.

Reset
REQ-029 SHALL, with reset_n low at an edge, set the FSM to IDLE and done, err, q_written, action_out, reward_out and all data_out to 0.
REQ-030 SHALL abort an in-flight request on reset with no RAM write; table contents are not reset.
REQ-031 SHALL assert req_ready the first cycle after reset_n returns high.

Configuration
REQ-032 SHALL, with QCTRL_CLEAR_EN defined, add port clear (input, 1) and port clear_busy (output, 1).
REQ-033 SHALL, with QCTRL_CLEAR_EN defined, enter state CLEAR on clear in IDLE, writing 0 to all 9 lanes of rows 0..2^ADDR_W-1 at one row per cycle, with clear_busy=1 and req_ready=0.
REQ-034 SHALL, with QCTRL_CLEAR_EN defined, ignore clear outside IDLE; clear has priority over a simultaneous req_valid.
REQ-035 SHALL, without QCTRL_CLEAR_EN, omit the clear ports and the CLEAR state; power-up table contents are undefined.

Structure
REQ-036 SHALL place NUM_ACTIONS=9, Q_W=16 and the FSM state enum in shared package q_pkg.
REQ-037 SHALL use one sub-module, q_row_ram: synchronous single-port RAM 2^ADDR_W x (9*Q_W) with 9 lane write-enables.

Verification (compiled with QCTRL_CLEAR_EN)
REQ-038 SHALL cover: clear, then request state=3, next=5, action=2, reward=0x0010 with bench q_new=0x1234 -> done 4 cycles after accept, q_written=0x1234, err=0; a re-request on state=3 shows data_out2=0x1234 and the other lanes 0 in PRES_S.
REQ-039 SHALL cover: action_in=0 with q_new=0x5555 -> done with err=1; row unchanged on re-read.
REQ-040 SHALL cover: state=next=7 holding lane4=0x0100 -> PRES_S and PRES_NS both present lane4=0x0100.
REQ-041 SHALL cover: reset_n low during PRES_S -> all outputs 0 next cycle, req_ready=1 after release, no write.
REQ-042 SHALL cover: req_valid held high for two requests on the same state -> accepts 5 cycles apart, and the second PRES_S shows the first's write.
REQ-043 SHALL cover: clear during PRES_NS is ignored; clear in IDLE with ADDR_W=6 -> clear_busy high for 64 cycles, then all rows read 0.

Source files
------------

// File: rtl/q_pkg.sv
// Shared widths, FSM state encoding and lane helpers for the Q-table controller.
package q_pkg;

    localparam int unsigned NUM_ACTIONS = 9;
    localparam int unsigned Q_W         = 16;
    localparam int unsigned ACT_W       = 4;
    localparam int unsigned ROW_W       = NUM_ACTIONS * Q_W;

    typedef enum logic [2:0] {
        Q_IDLE    = 3'd0,
        Q_RD_S    = 3'd1,
        Q_PRES_S  = 3'd2,
        Q_PRES_NS = 3'd3,
        Q_DONE    = 3'd4,
        Q_CLEAR   = 3'd5
    } q_state_e;

    // Per-request payload held for the accelerator while the rows are presented.
    typedef struct packed {
        logic [ACT_W-1:0] action;
        logic [Q_W-1:0]   reward;
    } q_req_t;

    function automatic logic is_legal(input logic [ACT_W-1:0] action);
        return (action != '0) && (action <= ACT_W'(NUM_ACTIONS));
    endfunction

    // One-hot lane write-enable for actions 1..9; all-zero for illegal actions.
    function automatic logic [NUM_ACTIONS-1:0] lane_sel(input logic [ACT_W-1:0] action);
        logic [NUM_ACTIONS-1:0] sel;
        sel = '0;
        if (is_legal(action)) begin
            sel[action - ACT_W'(1)] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/q_row_ram.sv
// Synchronous single-port Q-row RAM, 2^ADDR_W rows of 9 lanes, per-lane write enables.
module q_row_ram
    import q_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic                   clock,
    input  logic                   en,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [NUM_ACTIONS-1:0] lane_we,
    input  logic [ROW_W-1:0]       wdata,
    output logic [ROW_W-1:0]       rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [ROW_W-1:0] mem [DEPTH];

    // Read-first: rdata returns the row as it was before a same-cycle write.
    always_ff @(posedge clock) begin
        if (en) begin
            for (int l = 0; l < NUM_ACTIONS; l++) begin
                if (lane_we[l]) begin
                    mem[addr][l*Q_W +: Q_W] <= wdata[l*Q_W +: Q_W];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/q_table_ctrl.sv
// Q-table controller: reads current/next rows for the accelerator and writes back q_new.
// Optional table-clear engine (clear / clear_busy ports) when QCTRL_CLEAR_EN is defined.
module q_table_ctrl
    import q_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset_n,
`ifdef QCTRL_CLEAR_EN
    input  logic              clear,
    output logic              clear_busy,
`endif
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] state_idx,
    input  logic [ADDR_W-1:0] next_idx,
    input  logic [ACT_W-1:0]  action_in,
    input  logic [Q_W-1:0]    reward_in,
    output logic [Q_W-1:0]    data_out1,
    output logic [Q_W-1:0]    data_out2,
    output logic [Q_W-1:0]    data_out3,
    output logic [Q_W-1:0]    data_out4,
    output logic [Q_W-1:0]    data_out5,
    output logic [Q_W-1:0]    data_out6,
    output logic [Q_W-1:0]    data_out7,
    output logic [Q_W-1:0]    data_out8,
    output logic [Q_W-1:0]    data_out9,
    output logic [ACT_W-1:0]  action_out,
    output logic [Q_W-1:0]    reward_out,
    input  logic [Q_W-1:0]    q_new,
    output logic              done,
    output logic [Q_W-1:0]    q_written,
    output logic              err
);

    localparam logic [2:0] ST_IDLE    = Q_IDLE;
    localparam logic [2:0] ST_RD_S    = Q_RD_S;
    localparam logic [2:0] ST_PRES_S  = Q_PRES_S;
    localparam logic [2:0] ST_PRES_NS = Q_PRES_NS;
    localparam logic [2:0] ST_DONE    = Q_DONE;
`ifdef QCTRL_CLEAR_EN
    localparam logic [2:0] ST_CLEAR   = Q_CLEAR;
`endif

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [ADDR_W-1:0]      s_idx_q;
    logic [ADDR_W-1:0]      n_idx_q;
    q_req_t                 req_q;
    logic                   accept;
    logic                   presenting;
    logic                   presenting_nxt;

    logic                   ram_en;
    logic [ADDR_W-1:0]      ram_addr;
    logic [NUM_ACTIONS-1:0] ram_we;
    logic [ROW_W-1:0]       ram_wdata;
    logic [ROW_W-1:0]       ram_rdata;
    logic [Q_W-1:0]         lane [NUM_ACTIONS];

`ifdef QCTRL_CLEAR_EN
    logic                   clear_go;
    logic                   clr_last;
    logic [ADDR_W-1:0]      clr_row;

    // Clear wins over a simultaneous request and is only honoured in IDLE.
    assign clear_go = clear && (state == ST_IDLE);
    assign clr_last = (clr_row == '1);
    assign accept   = req_valid && req_ready && !clear_go;
`else
    assign accept   = req_valid && req_ready;
`endif

    assign presenting     = (state == ST_PRES_S) || (state == ST_PRES_NS);
    assign presenting_nxt = (state_nxt == ST_PRES_S) || (state_nxt == ST_PRES_NS);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_RD_S;
                end
`ifdef QCTRL_CLEAR_EN
                if (clear_go) begin
                    state_nxt = ST_CLEAR;
                end
`endif
            end
            ST_RD_S:    state_nxt = ST_PRES_S;
            ST_PRES_S:  state_nxt = ST_PRES_NS;
            ST_PRES_NS: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
`ifdef QCTRL_CLEAR_EN
            ST_CLEAR: begin
                if (clr_last) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // RAM port sequencing; writes are masked while reset is asserted so an aborted request never commits.
    always_comb begin
        ram_en    = 1'b0;
        ram_addr  = s_idx_q;
        ram_we    = '0;
        ram_wdata = {NUM_ACTIONS{q_new}};
        case (state)
            ST_RD_S: begin
                ram_en = 1'b1;
            end
            ST_PRES_S: begin
                ram_en   = 1'b1;
                ram_addr = n_idx_q;
            end
            ST_PRES_NS: begin
                ram_en = 1'b1;
                ram_we = lane_sel(req_q.action) & {NUM_ACTIONS{reset_n}};
            end
`ifdef QCTRL_CLEAR_EN
            ST_CLEAR: begin
                ram_en    = 1'b1;
                ram_addr  = clr_row;
                ram_we    = {NUM_ACTIONS{reset_n}};
                ram_wdata = '0;
            end
`endif
            default: begin
                ram_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            s_idx_q      <= state_idx;
            n_idx_q      <= next_idx;
            req_q.action <= action_in;
            req_q.reward <= reward_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            req_ready  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            q_written  <= '0;
            action_out <= '0;
            reward_out <= '0;
        end else begin
            req_ready  <= (state_nxt == ST_IDLE);
            done       <= (state_nxt == ST_DONE);
            err        <= (state == ST_PRES_NS) && !is_legal(req_q.action);
            q_written  <= (state == ST_PRES_NS) ? q_new : '0;
            action_out <= presenting_nxt ? req_q.action : '0;
            reward_out <= presenting_nxt ? req_q.reward : '0;
        end
    end

`ifdef QCTRL_CLEAR_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clr_row    <= '0;
            clear_busy <= 1'b0;
        end else begin
            clr_row    <= (state == ST_CLEAR) ? clr_row + ADDR_W'(1) : '0;
            clear_busy <= (state_nxt == ST_CLEAR);
        end
    end
`endif

    // Lanes show the RAM row only while a row is being presented.
    always_comb begin
        for (int l = 0; l < NUM_ACTIONS; l++) begin
            lane[l] = presenting ? ram_rdata[l*Q_W +: Q_W] : '0;
        end
    end

    assign data_out1 = lane[0];
    assign data_out2 = lane[1];
    assign data_out3 = lane[2];
    assign data_out4 = lane[3];
    assign data_out5 = lane[4];
    assign data_out6 = lane[5];
    assign data_out7 = lane[6];
    assign data_out8 = lane[7];
    assign data_out9 = lane[8];

    q_row_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .en      (ram_en),
        .addr    (ram_addr),
        .lane_we (ram_we),
        .wdata   (ram_wdata),
        .rdata   (ram_rdata)
    );

endmodule
